wb_burst_sram_ctrl: RTL and testbench

Wishbone slave memory controller on the core's external bus, directly downstream of the core-side wishbone arbiter. It accepts single reads and writes, plus 4- and 8-beat read bursts from the icache/dcache refill paths. Requests are translated into accesses on a synchronous SRAM port with fixed read latency. Burst beats are pipelined so that after the initial latency one `wb_ack` is returned per cycle.

---
 rtl/wb_burst_sram_ctrl.sv | 158 +++++++++++++++
 tb/tb_wb_burst_sram_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_sram_ctrl.sv
// Wishbone slave: single reads/writes and wrapping 4/8-beat read bursts onto a fixed-latency sync SRAM.
// Read ack at T+RD_LAT+2 then one per cycle; dropping wb_cyc aborts and drains in-flight data.
module wb_burst_sram_ctrl #(
   parameter int ADDR_W     = 24,
   parameter int MEM_ADDR_W = 18,
   parameter int RD_LAT     = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   input  logic [ADDR_W-1:0]     wb_adr,
   input  logic [15:0]           wb_i_dat,
   input  logic [1:0]            wb_sel,
   input  logic                  wb_4_burst,
   input  logic                  wb_8_burst,
   output logic [15:0]           wb_o_dat,
   output logic                  wb_ack,
   output logic                  wb_err,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [1:0]            mem_be,
   output logic [15:0]           mem_wdata,
   input  logic [15:0]           mem_rdata
);
   typedef enum logic [2:0] {IDLE, READ, WRITE, ERR, DRAIN} state_t;

   state_t                state;
   logic [MEM_ADDR_W-1:0] base;
   logic [MEM_ADDR_W-1:0] mask;
   logic [2:0]            off;
   logic [2:0]            issue_left;
   logic [3:0]            ack_left;
   logic [3:0]            inflight;
   logic [RD_LAT-1:0]     pipe;
   logic                  cs_q;
   logic                  ack_q;
   logic                  err_q;
   logic                  issue;
   logic                  ret;
   logic                  out_of_range;
   logic [3:0]            n_beats;
   logic [MEM_ADDR_W-1:0] next_addr;

   assign out_of_range = (wb_adr >> MEM_ADDR_W) != '0;
   assign n_beats      = wb_8_burst ? 4'd8 : (wb_4_burst ? 4'd4 : 4'd1);
   // Low log2(N) address bits count, upper bits hold: wrap inside the aligned block.
   assign next_addr    = (base & ~mask) | ((base + MEM_ADDR_W'(off)) & mask);

   // A dropped wb_cyc suppresses the beat and the ack in that very cycle.
   assign mem_cs = cs_q & (wb_cyc | (state != READ));
   assign wb_ack = ack_q & wb_cyc;
   assign wb_err = err_q & wb_cyc;
   assign issue  = mem_cs & ~mem_we;
   assign ret    = pipe[RD_LAT-1];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state      <= IDLE;
         base       <= '0;
         mask       <= '0;
         off        <= '0;
         issue_left <= '0;
         ack_left   <= '0;
         inflight   <= '0;
         pipe       <= '0;
         cs_q       <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         wb_o_dat   <= '0;
      end else begin
         pipe     <= (pipe << 1) | RD_LAT'(issue);
         inflight <= inflight + 4'(issue) - 4'(ret);
         case (state)
            IDLE: begin
               cs_q   <= 1'b0;
               ack_q  <= 1'b0;
               err_q  <= 1'b0;
               mem_we <= 1'b0;
               if (wb_cyc && wb_stb) begin
                  if (out_of_range) begin
                     state <= ERR;
                     err_q <= 1'b1;
                  end else if (wb_we) begin
                     state     <= WRITE;
                     cs_q      <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= wb_adr[MEM_ADDR_W-1:0];
                     mem_be    <= wb_sel;
                     mem_wdata <= wb_i_dat;
                  end else begin
                     state      <= READ;
                     cs_q       <= 1'b1;
                     mem_addr   <= wb_adr[MEM_ADDR_W-1:0];
                     mem_be     <= 2'b11;
                     base       <= wb_adr[MEM_ADDR_W-1:0];
                     mask       <= MEM_ADDR_W'(n_beats - 4'd1);
                     off        <= 3'd1;
                     issue_left <= 3'(n_beats - 4'd1);
                     ack_left   <= n_beats;
                  end
               end
            end
            WRITE: begin
               cs_q   <= 1'b0;
               mem_we <= 1'b0;
               if (!ack_q) begin
                  ack_q <= 1'b1;
               end else begin
                  ack_q <= 1'b0;
                  state <= IDLE;
               end
            end
            READ: begin
               if (!wb_cyc) begin
                  cs_q  <= 1'b0;
                  ack_q <= 1'b0;
                  state <= DRAIN;
               end else if (ack_q && ack_left == 4'd0) begin
                  cs_q  <= 1'b0;
                  ack_q <= 1'b0;
                  state <= IDLE;
               end else begin
                  if (issue_left != 3'd0) begin
                     cs_q       <= 1'b1;
                     mem_addr   <= next_addr;
                     off        <= off + 3'd1;
                     issue_left <= issue_left - 3'd1;
                  end else begin
                     cs_q <= 1'b0;
                  end
                  ack_q <= ret;
                  if (ret) begin
                     wb_o_dat <= mem_rdata;
                     ack_left <= ack_left - 4'd1;
                  end
               end
            end
            ERR: begin
               err_q <= 1'b0;
               state <= IDLE;
            end
            DRAIN: begin
               cs_q  <= 1'b0;
               ack_q <= 1'b0;
               if (inflight == 4'd0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_burst_sram_ctrl.sv
// Bench for wb_burst_sram_ctrl: table of single accesses and bursts plus abort, reset and back-to-back sequences.
module tb_wb_burst_sram_ctrl;
   localparam int ADDR_W     = 24;
   localparam int MEM_ADDR_W = 18;
   localparam int RD_LAT     = 2;
   localparam int LOGN       = 4096;
   localparam int NV         = 14;

   logic                  i_clk = 1'b0;
   logic                  i_rst = 1'b0;
   logic                  wb_cyc = 1'b0;
   logic                  wb_stb = 1'b0;
   logic                  wb_we = 1'b0;
   logic [ADDR_W-1:0]     wb_adr = '0;
   logic [15:0]           wb_i_dat = '0;
   logic [1:0]            wb_sel = '0;
   logic                  wb_4_burst = 1'b0;
   logic                  wb_8_burst = 1'b0;
   logic [15:0]           wb_o_dat;
   logic                  wb_ack;
   logic                  wb_err;
   logic                  mem_cs;
   logic                  mem_we;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [1:0]            mem_be;
   logic [15:0]           mem_wdata;
   logic [15:0]           mem_rdata;

   wb_burst_sram_ctrl #(.ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .RD_LAT(RD_LAT)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
      .wb_adr(wb_adr), .wb_i_dat(wb_i_dat), .wb_sel(wb_sel), .wb_4_burst(wb_4_burst),
      .wb_8_burst(wb_8_burst), .wb_o_dat(wb_o_dat), .wb_ack(wb_ack), .wb_err(wb_err),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   // SRAM model: read data valid two cycles after the strobe cycle.
   logic [15:0] sram [0:(1<<MEM_ADDR_W)-1];
   logic [15:0] rd_d1;
   always @(posedge i_clk) begin
      if (mem_cs && mem_we) begin
         if (mem_be[0]) sram[mem_addr][7:0]  <= mem_wdata[7:0];
         if (mem_be[1]) sram[mem_addr][15:8] <= mem_wdata[15:8];
      end
      rd_d1     <= (mem_cs && !mem_we) ? sram[mem_addr] : 16'hDEAD;
      mem_rdata <= rd_d1;
   end

   int cyc_n = 0;
   always @(posedge i_clk) cyc_n <= cyc_n + 1;

   logic                  log_cs   [LOGN];
   logic                  log_we   [LOGN];
   logic                  log_ack  [LOGN];
   logic                  log_err  [LOGN];
   logic [MEM_ADDR_W-1:0] log_addr [LOGN];
   logic [1:0]            log_be   [LOGN];
   logic [15:0]           log_wdata[LOGN];
   logic [15:0]           log_dat  [LOGN];
   always @(negedge i_clk) begin
      if (cyc_n < LOGN) begin
         log_cs[cyc_n]    = mem_cs;
         log_we[cyc_n]    = mem_we;
         log_ack[cyc_n]   = wb_ack;
         log_err[cyc_n]   = wb_err;
         log_addr[cyc_n]  = mem_addr;
         log_be[cyc_n]    = mem_be;
         log_wdata[cyc_n] = mem_wdata;
         log_dat[cyc_n]   = wb_o_dat;
      end
   end

   typedef struct {
      logic        we;
      logic [23:0] adr;
      logic [15:0] dat;
      logic [1:0]  sel;
      logic        b4;
      logic        b8;
      int          exp_n;    // 0 means an error response is expected
      logic [15:0] exp_dat;  // read data for single reads
   } vec_t;

   vec_t vt [NV];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic int count_ack(input int a, input int b);
      int c = 0;
      for (int j = a; j <= b; j++) if (log_ack[j]) c++;
      return c;
   endfunction

   function automatic int count_cs(input int a, input int b);
      int c = 0;
      for (int j = a; j <= b; j++) if (log_cs[j]) c++;
      return c;
   endfunction

   // Classic master: stb held until the first ack/err; cyc held for the whole op.
   task automatic bus_op(input vec_t v, input int abort_at, input int rst_at, input int stop_k,
                         output int t0, output int nack, output int nerr, output logic [15:0] fdat);
      bit seen;
      seen = 1'b0;
      t0 = 0; nack = 0; nerr = 0; fdat = '0;
      for (int k = 0; k < 40; k++) begin
         @(posedge i_clk); #1;
         if (k == 0) begin
            t0 = cyc_n;
            wb_we = v.we; wb_adr = v.adr; wb_i_dat = v.dat; wb_sel = v.sel;
            wb_4_burst = v.b4; wb_8_burst = v.b8;
            wb_cyc = 1'b1; wb_stb = 1'b1;
         end
         if (seen) wb_stb = 1'b0;
         if (abort_at > 0 && k >= abort_at) begin
            wb_cyc = 1'b0; wb_stb = 1'b0;
         end
         if (rst_at > 0) i_rst = (k == rst_at) ? 1'b0 : 1'b1;
         @(negedge i_clk);
         if (wb_ack) begin
            if (nack == 0) fdat = wb_o_dat;
            nack++; seen = 1'b1;
         end
         if (wb_err) begin
            nerr++; seen = 1'b1;
         end
         if (stop_k > 0) begin
            if (k == stop_k) break;
         end else if (nerr > 0 || (v.exp_n > 0 && nack >= v.exp_n)) begin
            break;
         end
      end
   endtask

   task automatic gap(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge i_clk); #1;
         wb_stb = 1'b0; wb_cyc = 1'b1; wb_4_burst = 1'b0; wb_8_burst = 1'b0;
      end
      @(negedge i_clk);
   endtask

   int t0, t1, nack, nerr, n;
   logic [15:0] fdat;
   logic [MEM_ADDR_W-1:0] ea, msk;
   vec_t rv;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < (1 << MEM_ADDR_W); a++) sram[a] = a[15:0];
      sram[18'h00123] = 16'hBEEF;
      sram[18'h00010] = 16'h1111;
      sram[18'h00050] = 16'h5050;

      //         we    adr          dat       sel    b4    b8    N  exp_dat
      vt[0]  = '{1'b0, 24'h000123, 16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'hBEEF};
      vt[1]  = '{1'b1, 24'h000010, 16'hA55A, 2'b01, 1'b0, 1'b0, 1, 16'h0000};
      vt[2]  = '{1'b0, 24'h000010, 16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'h115A};
      vt[3]  = '{1'b1, 24'h000020, 16'h1234, 2'b00, 1'b0, 1'b0, 1, 16'h0000};
      vt[4]  = '{1'b0, 24'h000020, 16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'h0020};
      vt[5]  = '{1'b1, 24'h000040, 16'hAB00, 2'b10, 1'b0, 1'b1, 1, 16'h0000};
      vt[6]  = '{1'b0, 24'h000040, 16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'hAB40};
      vt[7]  = '{1'b0, 24'h03FFFF, 16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'hFFFF};
      vt[8]  = '{1'b0, 24'h000105, 16'h0000, 2'b11, 1'b1, 1'b0, 4, 16'h0000};
      vt[9]  = '{1'b0, 24'h000106, 16'h0000, 2'b11, 1'b0, 1'b1, 8, 16'h0000};
      vt[10] = '{1'b0, 24'h000101, 16'h0000, 2'b11, 1'b1, 1'b1, 8, 16'h0000};
      vt[11] = '{1'b0, 24'h040000, 16'h0000, 2'b11, 1'b1, 1'b0, 0, 16'h0000};
      vt[12] = '{1'b1, 24'hFFFFFF, 16'h9999, 2'b11, 1'b0, 1'b0, 0, 16'h0000};
      vt[13] = '{1'b0, 24'h000102, 16'h0000, 2'b11, 1'b1, 1'b0, 4, 16'h0000};

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("reset_outputs", {wb_ack, wb_err, mem_cs, mem_we, mem_addr, mem_be, mem_wdata, wb_o_dat}, 64'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      gap(2);

      for (int i = 0; i < NV; i++) begin
         bus_op(vt[i], 0, 0, 0, t0, nack, nerr, fdat);
         gap(3);
         n = vt[i].exp_n;
         if (n == 0) begin
            chk($sformatf("v%0d_err_pulse", i), {log_err[t0+1], log_err[t0+2]}, 2'b10);
            chk($sformatf("v%0d_err_count", i), nerr, 1);
            chk($sformatf("v%0d_err_noack", i), count_ack(t0, t0+4), 0);
            chk($sformatf("v%0d_err_nocs", i), count_cs(t0, t0+4), 0);
         end else if (vt[i].we) begin
            chk($sformatf("v%0d_wr_ctl", i), {log_cs[t0+1], log_we[t0+1], log_be[t0+1]}, {1'b1, 1'b1, vt[i].sel});
            chk($sformatf("v%0d_wr_addr", i), log_addr[t0+1], vt[i].adr[MEM_ADDR_W-1:0]);
            chk($sformatf("v%0d_wr_data", i), log_wdata[t0+1], vt[i].dat);
            chk($sformatf("v%0d_wr_ack", i), {log_ack[t0+1], log_ack[t0+2], log_ack[t0+3]}, 3'b010);
            chk($sformatf("v%0d_wr_cs_once", i), count_cs(t0+2, t0+4), 0);
         end else begin
            msk = MEM_ADDR_W'(n - 1);
            for (int b = 0; b < n; b++) begin
               ea = (vt[i].adr[MEM_ADDR_W-1:0] & ~msk) | ((vt[i].adr[MEM_ADDR_W-1:0] + MEM_ADDR_W'(b)) & msk);
               chk($sformatf("v%0d_rd_issue%0d", i, b),
                   {log_cs[t0+1+b], log_we[t0+1+b], log_be[t0+1+b], log_addr[t0+1+b]}, {1'b1, 1'b0, 2'b11, ea});
               chk($sformatf("v%0d_rd_ack%0d", i, b), {log_ack[t0+RD_LAT+2+b], log_dat[t0+RD_LAT+2+b]},
                   {1'b1, (n == 1) ? vt[i].exp_dat : ea[15:0]});
            end
            chk($sformatf("v%0d_rd_cs_end", i), {log_cs[t0+1+n], log_cs[t0+RD_LAT+2+n]}, 2'b00);
            chk($sformatf("v%0d_rd_ack_edges", i), {log_ack[t0+RD_LAT+1], log_ack[t0+RD_LAT+2+n]}, 2'b00);
            chk($sformatf("v%0d_rd_nack", i), nack, n);
         end
      end

      // Write then read issued in the write's first IDLE cycle.
      rv = '{1'b1, 24'h000060, 16'h7777, 2'b11, 1'b0, 1'b0, 1, 16'h0000};
      bus_op(rv, 0, 0, 0, t0, nack, nerr, fdat);
      rv = '{1'b0, 24'h000060, 16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'h7777};
      bus_op(rv, 0, 0, 0, t1, nack, nerr, fdat);
      gap(2);
      chk("b2b_wr_rd_start", t1 - t0, 3);
      chk("b2b_wr_rd_cs", {log_cs[t0+4], log_we[t0+4], log_addr[t0+4]}, {1'b1, 1'b0, 18'h00060});
      chk("b2b_wr_rd_ack", {log_ack[t0+7], log_dat[t0+7]}, {1'b1, 16'h7777});

      // 8-beat burst followed at once by a single read sampled at T+12.
      bus_op(vt[9], 0, 0, 0, t0, nack, nerr, fdat);
      bus_op(vt[0], 0, 0, 0, t1, nack, nerr, fdat);
      gap(2);
      chk("b2b_burst_acks", count_ack(t0+4, t0+11), 8);
      chk("b2b_burst_rd_cs", {count_cs(t0+9, t0+12), log_cs[t0+13], log_addr[t0+13]}, {32'd0, 1'b1, 18'h00123});
      chk("b2b_burst_rd_ack", {log_ack[t0+12], log_ack[t0+16], log_dat[t0+16]}, {2'b01, 16'hBEEF});

      // Abort an 8-burst by dropping wb_cyc at T+3, then a single read.
      rv = '{1'b0, 24'h000100, 16'h0000, 2'b11, 1'b0, 1'b1, 8, 16'h0000};
      bus_op(rv, 3, 0, 4, t0, nack, nerr, fdat);
      chk("abort_nack", nack, 0);
      chk("abort_cs_stop", log_cs[t0+4], 1'b0);
      rv = '{1'b0, 24'h000050, 16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'h5050};
      bus_op(rv, 0, 0, 0, t1, nack, nerr, fdat);
      gap(3);
      chk("abort_new_read_data", {nack[7:0], fdat}, {8'd1, 16'h5050});
      chk("abort_total_acks", count_ack(t0, t1 + 12), 1);

      // Reset asserted at T+5 of an 8-burst.
      rv = '{1'b0, 24'h000100, 16'h0000, 2'b11, 1'b0, 1'b1, 8, 16'h0000};
      bus_op(rv, 0, 5, 14, t0, nack, nerr, fdat);
      chk("rst_pre_acks", {nack[7:0], fdat}, {8'd2, 16'h0100});
      chk("rst_outputs_zero", {log_ack[t0+6], log_err[t0+6], log_cs[t0+6], log_we[t0+6], log_addr[t0+6],
                               log_be[t0+6], log_wdata[t0+6], log_dat[t0+6]}, 64'd0);
      chk("rst_no_late_ack", count_ack(t0+6, t0+14), 0);
      gap(2);
      bus_op(vt[0], 0, 0, 0, t1, nack, nerr, fdat);
      gap(2);
      chk("rst_then_read", {log_ack[t1+3], log_ack[t1+4], log_dat[t1+4], nack[7:0]}, {2'b01, 16'hBEEF, 8'd1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
